fft_frame_streamer: RTL and testbench

// - Snapshots one complete FFT result set when the FFT reports cycle done and serialises it byte-by-byte into UART_TX.
// - Supersedes the fixed 32-byte mux/counter path: FFT_SIZE, WORD_SIZE and real-only vs real+imag mode are parametrised.
// - Adds an optional sync header, an XOR checksum trailer and overrun detection.
// - Sits between FFT_for_OFDM (flattened outputs, cycle-done) and UART_TX (start/done handshake); fully synchronous.

---
 rtl/fft_pkg.sv | 31 +++
 rtl/fft_frame_byte_sel.sv | 40 ++++
 rtl/fft_frame_streamer.sv | 150 +++++++++++++++
 tb/tb_fft_frame_streamer.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame streamer.
//   stream_state_t      : streamer FSM states
//   DEFAULT_HEADER_BYTE : default sync byte sent ahead of the payload
//   frame_len()         : bytes per frame for a given configuration and mode
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_DONE,
    ST_FINISH
  } stream_state_t;

  localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;

  // Header (optional) + payload + checksum trailer (optional).
  // Mode 1 interleaves re and im, doubling the payload.
  function automatic int unsigned frame_len(
    input int unsigned fft_size,
    input int unsigned word_size,
    input int unsigned data_length,
    input bit          header_en,
    input bit          cksum_en,
    input bit          mode
  );
    int unsigned payload;
    payload = fft_size * (word_size / data_length) * (mode ? 2 : 1);
    return payload + {31'b0, header_en} + {31'b0, cksum_en};
  endfunction

endpackage

// File: rtl/fft_frame_byte_sel.sv
// Combinational payload byte selector.
//   re_flat / im_flat : snapshot of all bins, bin k at [k*WORD_SIZE +: WORD_SIZE]
//   mode              : 0 = re only, 1 = re then im per bin
//   index             : payload byte index (header excluded)
//   data              : selected byte; least significant byte of a word first
module fft_frame_byte_sel #(
  parameter int unsigned FFT_SIZE    = 16,
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned DATA_LENGTH = 8,
  parameter int unsigned IDX_W       = 7
) (
  input  logic [FFT_SIZE*WORD_SIZE-1:0] re_flat,
  input  logic [FFT_SIZE*WORD_SIZE-1:0] im_flat,
  input  logic                          mode,
  input  logic [IDX_W-1:0]              index,
  output logic [DATA_LENGTH-1:0]        data
);

  localparam int unsigned BPW = WORD_SIZE / DATA_LENGTH;

  // Every payload position is a compile-time constant, so this unrolls into
  // a flat compare-and-select mux with no dividers.
  always_comb begin
    data = '0;
    for (int unsigned k = 0; k < FFT_SIZE; k++) begin
      for (int unsigned b = 0; b < BPW; b++) begin
        if (!mode) begin
          if (index == IDX_W'(k*BPW + b))
            data = re_flat[k*WORD_SIZE + b*DATA_LENGTH +: DATA_LENGTH];
        end else begin
          if (index == IDX_W'(2*k*BPW + b))
            data = re_flat[k*WORD_SIZE + b*DATA_LENGTH +: DATA_LENGTH];
          if (index == IDX_W'(2*k*BPW + BPW + b))
            data = im_flat[k*WORD_SIZE + b*DATA_LENGTH +: DATA_LENGTH];
        end
      end
    end
  end

endmodule

// File: rtl/fft_frame_streamer.sv
// Captures one FFT result set on i_FFT_cycle_done and streams it byte by
// byte into UART_TX: optional sync header, payload, optional XOR trailer.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_mode             : 0 re only, 1 re+im interleaved (sampled at capture)
//   i_FFT_cycle_done   : FFT outputs valid this cycle
//   i_re_flat/i_im_flat: flattened bins
//   i_TX_done          : UART byte fully sent
//   o_TX_byte          : byte presented to UART_TX, stable until i_TX_done
//   o_TX_start         : one-cycle start pulse
//   o_busy             : frame in progress
//   o_frame_done       : one-cycle pulse after the last byte completes
//   o_overrun          : one-cycle pulse, capture request dropped while busy
module fft_frame_streamer
  import fft_pkg::*;
#(
  parameter int unsigned             FFT_SIZE    = 16,
  parameter int unsigned             WORD_SIZE   = 16,
  parameter int unsigned             DATA_LENGTH = 8,
  parameter bit                      HEADER_EN   = 1'b1,
  parameter logic [DATA_LENGTH-1:0]  HEADER_BYTE = DATA_LENGTH'(DEFAULT_HEADER_BYTE),
  parameter bit                      CKSUM_EN    = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_mode,
  input  logic                          i_FFT_cycle_done,
  input  logic [FFT_SIZE*WORD_SIZE-1:0] i_re_flat,
  input  logic [FFT_SIZE*WORD_SIZE-1:0] i_im_flat,
  input  logic                          i_TX_done,
  output logic [DATA_LENGTH-1:0]        o_TX_byte,
  output logic                          o_TX_start,
  output logic                          o_busy,
  output logic                          o_frame_done,
  output logic                          o_overrun
);

  localparam int unsigned LEN0  = frame_len(FFT_SIZE, WORD_SIZE, DATA_LENGTH,
                                            HEADER_EN, CKSUM_EN, 1'b0);
  localparam int unsigned LEN1  = frame_len(FFT_SIZE, WORD_SIZE, DATA_LENGTH,
                                            HEADER_EN, CKSUM_EN, 1'b1);
  localparam int unsigned CNT_W = $clog2(LEN1 + 1);

  if (WORD_SIZE % DATA_LENGTH != 0) begin : g_bad_word_size
    $error("WORD_SIZE must be an integer multiple of DATA_LENGTH");
  end

  stream_state_t                 state, state_nxt;
  logic [FFT_SIZE*WORD_SIZE-1:0] re_snap, im_snap;
  logic                          mode_snap;
  logic [CNT_W-1:0]              cnt;
  logic [CNT_W-1:0]              last_idx;
  logic [CNT_W-1:0]              payload_idx;
  logic [DATA_LENGTH-1:0]        cksum;
  logic [DATA_LENGTH-1:0]        payload_byte;
  logic [DATA_LENGTH-1:0]        cur_byte;
  logic                          is_header, is_cksum, is_last;

  fft_frame_byte_sel #(
    .FFT_SIZE    (FFT_SIZE),
    .WORD_SIZE   (WORD_SIZE),
    .DATA_LENGTH (DATA_LENGTH),
    .IDX_W       (CNT_W)
  ) u_byte_sel (
    .re_flat (re_snap),
    .im_flat (im_snap),
    .mode    (mode_snap),
    .index   (payload_idx),
    .data    (payload_byte)
  );

  // cnt is the position within the whole frame; header and trailer are
  // recognised by position, everything between is payload.
  always_comb begin
    last_idx    = mode_snap ? CNT_W'(LEN1 - 1) : CNT_W'(LEN0 - 1);
    is_last     = (cnt == last_idx);
    is_header   = HEADER_EN && (cnt == '0);
    is_cksum    = CKSUM_EN && is_last;
    payload_idx = cnt - CNT_W'(HEADER_EN);
    if (is_header)     cur_byte = HEADER_BYTE;
    else if (is_cksum) cur_byte = cksum;
    else               cur_byte = payload_byte;
  end

  always_comb begin
    state_nxt    = state;
    o_TX_byte    = '0;
    o_TX_start   = 1'b0;
    o_busy       = 1'b0;
    o_frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_FFT_cycle_done) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        o_busy     = 1'b1;
        o_TX_start = 1'b1;
        o_TX_byte  = cur_byte;
        state_nxt  = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // cnt, snapshot and cksum are all frozen here, so the byte holds.
        o_busy    = 1'b1;
        o_TX_byte = cur_byte;
        if (i_TX_done) state_nxt = is_last ? ST_FINISH : ST_LOAD;
      end
      ST_FINISH: begin
        o_frame_done = 1'b1;
        state_nxt    = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cksum     <= '0;
      mode_snap <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      state     <= state_nxt;
      o_overrun <= i_FFT_cycle_done && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (i_FFT_cycle_done) begin
            cnt       <= '0;
            cksum     <= '0;
            mode_snap <= i_mode;
          end
        end
        ST_LOAD: begin
          if (!is_header && !is_cksum) cksum <= cksum ^ payload_byte;
        end
        ST_WAIT_DONE: begin
          if (i_TX_done && !is_last) cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && (state == ST_IDLE) && i_FFT_cycle_done) begin
      re_snap <= i_re_flat;
      im_snap <= i_im_flat;
    end
  end

endmodule

// File: tb/tb_fft_frame_streamer.sv
module tb_fft_frame_streamer;

  localparam int unsigned N        = 16;
  localparam int unsigned LONG_LAT = 868 * 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              mode  = 1'b0;
  logic              cfd_a = 1'b0;
  logic              cfd_b = 1'b0;
  logic [N*16-1:0]   re_flat = '0;
  logic [N*16-1:0]   im_flat = '0;
  logic              resp_done_a = 1'b0;
  logic              stray_done  = 1'b0;
  logic              resp_done_b = 1'b0;
  logic              done_a;
  assign done_a = resp_done_a | stray_done;

  logic [7:0] a_byte, b_byte;
  logic       a_start, a_busy, a_fd, a_ovr;
  logic       b_start, b_busy, b_fd, b_ovr;

  fft_frame_streamer #(
    .FFT_SIZE(16), .WORD_SIZE(16), .DATA_LENGTH(8),
    .HEADER_EN(1'b1), .HEADER_BYTE(8'hA5), .CKSUM_EN(1'b1)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_FFT_cycle_done(cfd_a),
    .i_re_flat(re_flat), .i_im_flat(im_flat), .i_TX_done(done_a),
    .o_TX_byte(a_byte), .o_TX_start(a_start), .o_busy(a_busy),
    .o_frame_done(a_fd), .o_overrun(a_ovr)
  );

  fft_frame_streamer #(
    .FFT_SIZE(16), .WORD_SIZE(16), .DATA_LENGTH(8),
    .HEADER_EN(1'b0), .HEADER_BYTE(8'hA5), .CKSUM_EN(1'b0)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_FFT_cycle_done(cfd_b),
    .i_re_flat(re_flat), .i_im_flat(im_flat), .i_TX_done(resp_done_b),
    .o_TX_byte(b_byte), .o_TX_start(b_start), .o_busy(b_busy),
    .o_frame_done(b_fd), .o_overrun(b_ovr)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] re_v [N];
  logic [15:0] im_v [N];
  logic [7:0]  exp_q [$];
  logic [7:0]  rx_a [$];
  logic [7:0]  rx_b [$];

  int a_starts = 0, a_frames = 0, a_ovrs = 0, b_frames = 0;
  int lat_a = 0, long_left = 0;
  int gap_seen = 0, gap_bad = 0, stab_seen = 0, stab_bad = 0;
  bit a_serving = 1'b0;

  always @(negedge clk) begin
    if (a_start) a_starts++;
    if (a_fd)    a_frames++;
    if (a_ovr)   a_ovrs++;
    if (b_fd)    b_frames++;
  end

  // UART_TX model for dut_a: programmable done latency, records each byte,
  // notes byte stability while waiting and whether the next start (or
  // frame_done) appears exactly one cycle after done.
  initial begin
    forever begin
      @(posedge clk); #1;
      while (a_start === 1'b1) begin
        logic [7:0] b;
        int         l;
        bit         stable;
        bit         busy_then;
        b = a_byte;
        rx_a.push_back(b);
        a_serving = 1'b1;
        if (long_left > 0) begin
          l = LONG_LAT;
          long_left--;
        end else begin
          l = lat_a;
        end
        stable = 1'b1;
        @(posedge clk); #1;
        repeat (l) begin
          if (a_busy && a_byte !== b) stable = 1'b0;
          @(posedge clk); #1;
        end
        if (a_busy && a_byte !== b) stable = 1'b0;
        busy_then = a_busy;
        resp_done_a = 1'b1;
        @(posedge clk); #1;
        resp_done_a = 1'b0;
        a_serving = 1'b0;
        if (l == LONG_LAT) begin
          stab_seen++;
          if (!stable) stab_bad++;
        end
        if (busy_then) begin
          gap_seen++;
          if ((a_start | a_fd) !== 1'b1) gap_bad++;
        end
      end
    end
  end

  // UART_TX model for dut_b: zero extra latency.
  initial begin
    forever begin
      @(posedge clk); #1;
      while (b_start === 1'b1) begin
        rx_b.push_back(b_byte);
        @(posedge clk); #1;
        resp_done_b = 1'b1;
        @(posedge clk); #1;
        resp_done_b = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic load_data();
    for (int k = 0; k < N; k++) begin
      re_flat[k*16 +: 16] = re_v[k];
      im_flat[k*16 +: 16] = im_v[k];
    end
  endtask

  task automatic pulse_a(input logic md);
    load_data();
    mode  = md;
    cfd_a = 1'b1;
    tick(1);
    cfd_a = 1'b0;
  endtask

  // Reference frame: header, bins ascending, re then im, LSB first, XOR trailer.
  task automatic build_exp(input bit md, input bit hdr, input bit ck);
    logic [7:0] x;
    x = 8'h00;
    exp_q.delete();
    if (hdr) exp_q.push_back(8'hA5);
    for (int k = 0; k < N; k++) begin
      exp_q.push_back(re_v[k][7:0]);
      exp_q.push_back(re_v[k][15:8]);
      x = x ^ re_v[k][7:0] ^ re_v[k][15:8];
      if (md) begin
        exp_q.push_back(im_v[k][7:0]);
        exp_q.push_back(im_v[k][15:8]);
        x = x ^ im_v[k][7:0] ^ im_v[k][15:8];
      end
    end
    if (ck) exp_q.push_back(x);
  endtask

  task automatic wait_a_frames(input int target, input int budget, output bit ok);
    int n;
    n = 0;
    while (a_frames < target && n < budget) begin
      tick(1);
      n++;
    end
    ok = (a_frames >= target);
  endtask

  task automatic wait_rx_a(input int target, input int budget, output bit ok);
    int n;
    n = 0;
    while (rx_a.size() < target && n < budget) begin
      tick(1);
      n++;
    end
    ok = (rx_a.size() >= target);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++; if (a_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %0h expected 0", a_byte); end
    checks++; if (a_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %0b expected 0", a_start); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", a_busy); end
    checks++; if (a_fd !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0b expected 0", a_fd); end
    checks++; if (a_ovr !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b expected 0", a_ovr); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_busy_b: got %0b expected 0", b_busy); end
    rst = 1'b0;
    tick(2);
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%0b expected 0", a_busy); end
  endtask

  task automatic test_mode0_plain();
    int base, f0, n;
    for (int k = 0; k < N; k++) begin
      re_v[k] = 16'h0100 + 16'(k);
      im_v[k] = 16'hDEAD;
    end
    base = rx_b.size();
    f0   = b_frames;
    load_data();
    mode  = 1'b0;
    cfd_b = 1'b1;
    tick(1);
    cfd_b = 1'b0;
    n = 0;
    while (b_frames == f0 && n < 500) begin tick(1); n++; end
    tick(10);
    build_exp(1'b0, 1'b0, 1'b0);
    checks++; if (b_frames - f0 !== 1) begin errors++; $display("FAIL plain_frame_done: got %0d pulses expected 1", b_frames - f0); end
    checks++; if (rx_b.size() - base !== 32) begin errors++; $display("FAIL plain_length: got %0d expected 32", rx_b.size() - base); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < rx_b.size()) begin
        checks++;
        if (rx_b[base+i] !== exp_q[i]) begin errors++; $display("FAIL plain_byte[%0d]: got %0h expected %0h", i, rx_b[base+i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_mode1_hdr_cksum();
    int base, f0, o0;
    bit ok;
    for (int k = 0; k < N; k++) begin
      re_v[k] = 16'(k);
      im_v[k] = 16'hFF00;
    end
    lat_a = 0;
    base = rx_a.size(); f0 = a_frames; o0 = a_ovrs;
    pulse_a(1'b1);
    wait_a_frames(f0 + 1, 1000, ok);
    tick(5);
    build_exp(1'b1, 1'b1, 1'b1);
    checks++; if (!ok) begin errors++; $display("FAIL m1_timeout: frames=%0d expected %0d", a_frames, f0 + 1); end
    checks++; if (rx_a.size() - base !== 66) begin errors++; $display("FAIL m1_length: got %0d expected 66", rx_a.size() - base); end
    checks++; if (a_ovrs - o0 !== 0) begin errors++; $display("FAIL m1_overrun: got %0d expected 0", a_ovrs - o0); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < rx_a.size()) begin
        checks++;
        if (rx_a[base+i] !== exp_q[i]) begin errors++; $display("FAIL m1_byte[%0d]: got %0h expected %0h", i, rx_a[base+i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_latency();
    int base, f0, gs0, gb0, ss0, sb0;
    bit ok;
    for (int k = 0; k < N; k++) begin
      re_v[k] = 16'(16'h1357 * (k + 1));
      im_v[k] = 16'h0000;
    end
    lat_a = 0;
    base = rx_a.size(); f0 = a_frames;
    gs0 = gap_seen; gb0 = gap_bad; ss0 = stab_seen; sb0 = stab_bad;
    long_left = 3;
    pulse_a(1'b0);
    wait_a_frames(f0 + 1, 30000, ok);
    tick(5);
    build_exp(1'b0, 1'b1, 1'b1);
    checks++; if (!ok) begin errors++; $display("FAIL lat_timeout: frames=%0d expected %0d", a_frames, f0 + 1); end
    checks++; if (rx_a.size() - base !== 34) begin errors++; $display("FAIL lat_length: got %0d expected 34", rx_a.size() - base); end
    checks++; if (stab_seen - ss0 !== 3) begin errors++; $display("FAIL lat_long_waits: got %0d expected 3", stab_seen - ss0); end
    checks++; if (stab_bad - sb0 !== 0) begin errors++; $display("FAIL lat_byte_stable: unstable=%0d expected 0", stab_bad - sb0); end
    checks++; if (gap_seen - gs0 !== 34) begin errors++; $display("FAIL lat_done_count: got %0d expected 34", gap_seen - gs0); end
    checks++; if (gap_bad - gb0 !== 0) begin errors++; $display("FAIL lat_start_gap: late=%0d expected 0", gap_bad - gb0); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < rx_a.size()) begin
        checks++;
        if (rx_a[base+i] !== exp_q[i]) begin errors++; $display("FAIL lat_byte[%0d]: got %0h expected %0h", i, rx_a[base+i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_overrun();
    int base, f0, o0;
    bit ok1, ok2;
    for (int k = 0; k < N; k++) begin
      re_v[k] = 16'hA000 + 16'(k * 16'h0111);
      im_v[k] = 16'h5000 + 16'(k);
    end
    build_exp(1'b1, 1'b1, 1'b1);
    lat_a = 0;
    base = rx_a.size(); f0 = a_frames; o0 = a_ovrs;
    pulse_a(1'b1);
    wait_rx_a(base + 11, 200, ok1);
    for (int k = 0; k < N; k++) begin
      re_v[k] = ~re_v[k];
      im_v[k] = 16'h1234;
    end
    pulse_a(1'b0);
    wait_a_frames(f0 + 1, 1000, ok2);
    tick(5);
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL ovr_timeout: rx=%0d frames=%0d", rx_a.size() - base, a_frames - f0); end
    checks++; if (a_ovrs - o0 !== 1) begin errors++; $display("FAIL ovr_pulse: got %0d expected 1", a_ovrs - o0); end
    checks++; if (a_frames - f0 !== 1) begin errors++; $display("FAIL ovr_frames: got %0d expected 1", a_frames - f0); end
    checks++; if (rx_a.size() - base !== 66) begin errors++; $display("FAIL ovr_length: got %0d expected 66", rx_a.size() - base); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < rx_a.size()) begin
        checks++;
        if (rx_a[base+i] !== exp_q[i]) begin errors++; $display("FAIL ovr_byte[%0d]: got %0h expected %0h", i, rx_a[base+i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int base, f0, s0, n;
    bit ok;
    for (int k = 0; k < N; k++) begin
      re_v[k] = 16'h0F0F ^ 16'(k << 4);
      im_v[k] = 16'h0000;
    end
    lat_a = 20;
    base = rx_a.size();
    pulse_a(1'b0);
    wait_rx_a(base + 6, 500, ok);
    tick(3);
    rst = 1'b1;
    tick(1);
    checks++; if (!ok) begin errors++; $display("FAIL rst_timeout: rx=%0d expected 6", rx_a.size() - base); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", a_busy); end
    checks++; if (a_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %0b expected 0", a_start); end
    checks++; if (a_byte !== 8'h00) begin errors++; $display("FAIL rst_byte: got %0h expected 0", a_byte); end
    checks++; if (a_fd !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %0b expected 0", a_fd); end
    s0 = a_starts;
    tick(1);
    rst = 1'b0;
    n = 0;
    while (a_serving && n < 200) begin tick(1); n++; end
    tick(5);
    checks++; if (a_starts - s0 !== 0) begin errors++; $display("FAIL rst_no_start: got %0d starts expected 0", a_starts - s0); end
    for (int k = 0; k < N; k++) begin
      re_v[k] = 16'(k * 3);
      im_v[k] = 16'h8000 | 16'(k);
    end
    lat_a = 0;
    base = rx_a.size(); f0 = a_frames;
    pulse_a(1'b1);
    wait_a_frames(f0 + 1, 1000, ok);
    tick(5);
    build_exp(1'b1, 1'b1, 1'b1);
    checks++; if (!ok) begin errors++; $display("FAIL rst_new_timeout: frames=%0d expected %0d", a_frames, f0 + 1); end
    checks++; if (rx_a.size() - base !== 66) begin errors++; $display("FAIL rst_new_length: got %0d expected 66", rx_a.size() - base); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < rx_a.size()) begin
        checks++;
        if (rx_a[base+i] !== exp_q[i]) begin errors++; $display("FAIL rst_new_byte[%0d]: got %0h expected %0h", i, rx_a[base+i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_stray_done_mode_toggle();
    int base, f0, s0;
    bit ok1, ok2;
    s0 = a_starts;
    stray_done = 1'b1;
    tick(1);
    stray_done = 1'b0;
    tick(5);
    checks++; if (a_starts - s0 !== 0) begin errors++; $display("FAIL stray_start: got %0d starts expected 0", a_starts - s0); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL stray_busy: got %0b expected 0", a_busy); end
    for (int k = 0; k < N; k++) begin
      re_v[k] = 16'hC3A5 - 16'(k * 7);
      im_v[k] = 16'h7777;
    end
    lat_a = 0;
    base = rx_a.size(); f0 = a_frames;
    pulse_a(1'b0);
    wait_rx_a(base + 4, 200, ok1);
    mode = 1'b1;
    tick(3);
    mode = 1'b0;
    tick(2);
    mode = 1'b1;
    wait_a_frames(f0 + 1, 1000, ok2);
    tick(5);
    mode = 1'b0;
    build_exp(1'b0, 1'b1, 1'b1);
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL toggle_timeout: rx=%0d frames=%0d", rx_a.size() - base, a_frames - f0); end
    checks++; if (rx_a.size() - base !== 34) begin errors++; $display("FAIL toggle_length: got %0d expected 34", rx_a.size() - base); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < rx_a.size()) begin
        checks++;
        if (rx_a[base+i] !== exp_q[i]) begin errors++; $display("FAIL toggle_byte[%0d]: got %0h expected %0h", i, rx_a[base+i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode0_plain();
    test_mode1_hdr_cksum();
    test_latency();
    test_overrun();
    test_reset_midframe();
    test_stray_done_mode_toggle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
